// File: rtl/trng_vn_collector_pkg.sv
// Shared types and default sizing for the TRNG von Neumann collector.
package trng_vn_collector_pkg;

  localparam int unsigned TRNG_WORD_SIZE = 32;
  localparam int unsigned VN_DISCARD_MAX = 32;

  typedef enum logic {
    P_FIRST  = 1'b0,
    P_SECOND = 1'b1
  } pair_state_e;

endpackage

// File: rtl/trng_vn_collector_pair.sv
// Von Neumann pair extractor with consecutive-discard watchdog; bypass passes every sample.
module trng_vn_pair
  import trng_vn_collector_pkg::*;
#(
  parameter int unsigned DISCARD_MAX = VN_DISCARD_MAX
) (
  input  logic rng_clk,
  input  logic rst_n,
  input  logic strobe,
  input  logic rnd_bit,
  input  logic bypass,
  input  logic clear,
  output logic emit_vld,
  output logic emit_bit,
  output logic vn_err
);

  localparam int unsigned DC_W = $clog2(DISCARD_MAX + 1);
  localparam logic [DC_W-1:0] DMAX = DC_W'(DISCARD_MAX);

  pair_state_e     state, state_nxt;
  logic            first, first_nxt;
  logic [DC_W-1:0] disc_cnt, disc_nxt;
  logic            err_nxt;

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= P_FIRST;
      first    <= 1'b0;
      disc_cnt <= '0;
      vn_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      first    <= first_nxt;
      disc_cnt <= disc_nxt;
      vn_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    first_nxt = first;
    disc_nxt  = disc_cnt;
    err_nxt   = vn_err;
    emit_vld  = 1'b0;
    emit_bit  = 1'b0;
    if (clear) begin
      state_nxt = P_FIRST;
      first_nxt = 1'b0;
      disc_nxt  = '0;
      err_nxt   = 1'b0;
    end else if (bypass) begin
      // Forcing P_FIRST here is what drops a half-collected pair on a bypass toggle.
      state_nxt = P_FIRST;
      disc_nxt  = '0;
      emit_vld  = strobe;
      emit_bit  = rnd_bit;
    end else if (strobe) begin
      case (state)
        P_FIRST: begin
          first_nxt = rnd_bit;
          state_nxt = P_SECOND;
        end
        P_SECOND: begin
          state_nxt = P_FIRST;
          if (rnd_bit != first) begin
            emit_vld = 1'b1;
            emit_bit = first;
            disc_nxt = '0;
          end else begin
            if (disc_cnt != DMAX) disc_nxt = disc_cnt + 1'b1;
            if (disc_nxt == DMAX) err_nxt = 1'b1;
          end
        end
        default: state_nxt = P_FIRST;
      endcase
    end
  end

endmodule

// File: rtl/trng_vn_collector.sv
// Collects debiased ROSC bits MSB-first into words and offers them on a valid/ready port.
module trng_vn_collector
  import trng_vn_collector_pkg::*;
#(
  parameter int unsigned WORD_W      = TRNG_WORD_SIZE,
  parameter int unsigned DISCARD_MAX = VN_DISCARD_MAX,
  parameter int unsigned CNT_W       = $clog2(WORD_W)
) (
  input  logic              rng_clk,
  input  logic              rst_n,
  input  logic              rst_trng_logic,
  input  logic              rnd_bit,
  input  logic              cntr_balance_valid,
  input  logic              vnc_bypass,
  input  logic              word_ready,
  output logic [WORD_W-1:0] rnd_word,
  output logic              rnd_word_valid,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              ovf_err,
  output logic              vn_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  logic              emit_vld;
  logic              emit_bit;
  logic [WORD_W-2:0] sr;
  logic [WORD_W-1:0] word_c;

  trng_vn_pair #(
    .DISCARD_MAX (DISCARD_MAX)
  ) u_pair (
    .rng_clk  (rng_clk),
    .rst_n    (rst_n),
    .strobe   (cntr_balance_valid),
    .rnd_bit  (rnd_bit),
    .bypass   (vnc_bypass),
    .clear    (rst_trng_logic),
    .emit_vld (emit_vld),
    .emit_bit (emit_bit),
    .vn_err   (vn_err)
  );

  assign word_c = {sr, emit_bit};

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr             <= '0;
      bit_cnt        <= '0;
      rnd_word       <= '0;
      rnd_word_valid <= 1'b0;
      ovf_err        <= 1'b0;
    end else if (rst_trng_logic) begin
      sr             <= '0;
      bit_cnt        <= '0;
      rnd_word       <= '0;
      rnd_word_valid <= 1'b0;
      ovf_err        <= 1'b0;
    end else begin
      if (rnd_word_valid && word_ready) rnd_word_valid <= 1'b0;
      if (emit_vld) begin
        sr <= word_c[WORD_W-2:0];
        if (bit_cnt == LAST) begin
          bit_cnt <= '0;
          // A load in the transfer cycle overrides the valid drop above.
          if (!rnd_word_valid || word_ready) begin
            rnd_word       <= word_c;
            rnd_word_valid <= 1'b1;
          end else begin
            ovf_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_vn_collector.sv
// Directed bench with an expected-word scoreboard checked by a handshake monitor.
module tb_trng_vn_collector;

  logic        rng_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_trng_logic = 1'b0;
  logic        rnd_bit = 1'b0;
  logic        cntr_balance_valid = 1'b0;
  logic        vnc_bypass = 1'b0;
  logic        word_ready = 1'b1;
  logic [31:0] rnd_word;
  logic        rnd_word_valid;
  logic [4:0]  bit_cnt;
  logic        ovf_err;
  logic        vn_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];

  trng_vn_collector #(
    .WORD_W      (32),
    .DISCARD_MAX (32)
  ) dut (
    .rng_clk            (rng_clk),
    .rst_n              (rst_n),
    .rst_trng_logic     (rst_trng_logic),
    .rnd_bit            (rnd_bit),
    .cntr_balance_valid (cntr_balance_valid),
    .vnc_bypass         (vnc_bypass),
    .word_ready         (word_ready),
    .rnd_word           (rnd_word),
    .rnd_word_valid     (rnd_word_valid),
    .bit_cnt            (bit_cnt),
    .ovf_err            (ovf_err),
    .vn_err             (vn_err)
  );

  always #5 rng_clk = ~rng_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge rng_clk) begin
    if (rst_n && rnd_word_valid && word_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got %h expected none", rnd_word);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rnd_word !== e) begin
          n_err++;
          $display("FAIL word: got %h expected %h", rnd_word, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge rng_clk);
    #1;
  endtask

  task automatic send(input logic b);
    rnd_bit = b;
    cntr_balance_valid = 1'b1;
    tick();
    cntr_balance_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) send(w[31-i]);
  endtask

  task automatic soft_clear();
    rst_trng_logic = 1'b1;
    tick();
    rst_trng_logic = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_valid", 32'(rnd_word_valid), 32'd0);
    check("reset_word", rnd_word, 32'd0);
    check("reset_cnt", 32'(bit_cnt), 32'd0);
    check("reset_flags", {30'd0, ovf_err, vn_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Bypass: alternating bits.
    vnc_bypass = 1'b1;
    exp_q.push_back(32'hAAAA_AAAA);
    send_word(32'hAAAA_AAAA, 31);
    check("byp_valid_before", 32'(rnd_word_valid), 32'd0);
    send(1'b0);
    check("byp_valid_after", 32'(rnd_word_valid), 32'd1);
    check("byp_cnt", 32'(bit_cnt), 32'd0);
    tick();
    check("byp_valid_drop", 32'(rnd_word_valid), 32'd0);

    // Debiased pairs.
    vnc_bypass = 1'b0;
    exp_q.push_back(32'hFFFF_FFFF);
    for (int unsigned i = 0; i < 32; i++) begin send(1'b1); send(1'b0); end
    exp_q.push_back(32'h0000_0000);
    for (int unsigned i = 0; i < 32; i++) begin send(1'b0); send(1'b1); end
    check("vn_no_err", 32'(vn_err), 32'd0);
    tick();
    tick();

    // Stuck source.
    for (int unsigned i = 0; i < 63; i++) send(1'b1);
    check("stuck_err_63", 32'(vn_err), 32'd0);
    send(1'b1);
    check("stuck_err_64", 32'(vn_err), 32'd1);
    check("stuck_no_word", {31'd0, rnd_word_valid}, 32'd0);
    check("stuck_cnt", 32'(bit_cnt), 32'd0);
    send(1'b1);
    send(1'b0);
    check("stuck_sticky", 32'(vn_err), 32'd1);
    check("stuck_pair_cnt", 32'(bit_cnt), 32'd1);
    soft_clear();
    check("clear_vn_err", 32'(vn_err), 32'd0);

    // Overflow with stalled consumer.
    vnc_bypass = 1'b1;
    word_ready = 1'b0;
    exp_q.push_back(32'h1234_5678);
    send_word(32'h1234_5678, 32);
    send_word(32'hFFFF_0000, 32);
    check("ovf_flag", 32'(ovf_err), 32'd1);
    check("ovf_valid", 32'(rnd_word_valid), 32'd1);
    check("ovf_held", rnd_word, 32'h1234_5678);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("ovf_drain_valid", 32'(rnd_word_valid), 32'd0);
    soft_clear();
    check("clear_ovf", 32'(ovf_err), 32'd0);

    // Completion coinciding with acceptance of the previous word.
    exp_q.push_back(32'hC3A5_0F96);
    send_word(32'hC3A5_0F96, 32);
    exp_q.push_back(32'h5A5A_1234);
    send_word(32'h5A5A_1234, 31);
    word_ready = 1'b1;
    send(1'b0);
    check("bb_valid", 32'(rnd_word_valid), 32'd1);
    check("bb_word", rnd_word, 32'h5A5A_1234);
    check("bb_ovf", 32'(ovf_err), 32'd0);
    tick();
    check("bb_drop", 32'(rnd_word_valid), 32'd0);

    // Soft clear with a partial word and a pending output.
    word_ready = 1'b0;
    send_word(32'hDEAD_BEEF, 32);
    send_word(32'hFFFF_FFFF, 17);
    check("sc_cnt_before", 32'(bit_cnt), 32'd17);
    check("sc_valid_before", 32'(rnd_word_valid), 32'd1);
    rnd_bit = 1'b1;
    cntr_balance_valid = 1'b1;
    rst_trng_logic = 1'b1;
    tick();
    cntr_balance_valid = 1'b0;
    rst_trng_logic = 1'b0;
    check("sc_cnt", 32'(bit_cnt), 32'd0);
    check("sc_valid", 32'(rnd_word_valid), 32'd0);
    check("sc_flags", {30'd0, ovf_err, vn_err}, 32'd0);
    word_ready = 1'b1;

    // Async reset mid-pair.
    vnc_bypass = 1'b0;
    send(1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", 32'(bit_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    send(1'b1);
    send(1'b0);
    send(1'b1);
    check("arst_fresh_pair", 32'(bit_cnt), 32'd1);
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
